// File: rtl/freq_meter.sv
// freq_meter
//   Gated frequency counter. The design counts rising edges of an asynchronous
//   input over a window of GATE_CYCLES clock cycles. It reports the count at the
//   end of each window, and windows run back to back while enable stays high.
//
// Parameters
//   GATE_CYCLES : window length in CLOCK cycles (default 1 s at 100 MHz)
//
// Ports
//   CLOCK    in   system clock
//   RESET    in   synchronous, active-high reset
//   sig_in   in   signal to measure, asynchronous to CLOCK
//   enable   in   1 = run measurement windows, 0 = stop / abort current window
//   freq     out  [31:0] edge count of the last completed window
//   valid    out  one-cycle pulse when freq/overflow update
//   overflow out  edge count saturated in the window reported by freq
//
// Configuration macro
//   FREQ_METER_AVG_EN : when defined, freq reports the mean of the current and
//                       previous window results. The first window after entering
//                       MEASURE reports its own result only.

module freq_meter #(
    parameter int GATE_CYCLES = 100000000
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        sig_in,
    input  logic        enable,
    output logic [31:0] freq,
    output logic        valid,
    output logic        overflow
);

    localparam logic [31:0] LAST_GATE = 32'(GATE_CYCLES - 1);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] MEASURE = 1'b1;

    logic [0:0]  state;
    logic        sync1;
    logic        sync2;
    logic        hist;
    logic        edge_det;
    logic [31:0] gate_cnt;
    logic [31:0] edge_cnt;
    logic        sat;
    logic        cnt_full;
    logic        inc;
    logic [31:0] result;
    logic        result_sat;

`ifdef FREQ_METER_AVG_EN
    logic [31:0] prev_result;
    logic        prev_sat;
    logic        have_prev;
`endif

    // The two-flop synchronizer and the history flop run in every state.
    // Because of this, the first detected edge after entering MEASURE reflects
    // real input history and not a stale power-up value.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    // Edge detection and the closing-window result.
    // An edge seen on the final gate cycle is folded into the result here.
    // The edge counter is cleared on that same cycle, so the edge is never
    // counted twice.
    // sat records that an edge arrived while the counter was already full,
    // which means at least one edge was lost.
    always_comb begin
        edge_det   = sync2 & ~hist;
        cnt_full   = &edge_cnt;
        inc        = edge_det & ~cnt_full;
        result     = edge_cnt + {31'd0, inc};
        result_sat = sat | (edge_det & cnt_full);
    end

    // Measurement FSM, counters and output registers.
    // Reset is checked first, so it overrides enable and also suppresses a
    // window that completes on the reset cycle.
    // Dropping enable aborts the window silently: freq and overflow keep the
    // last reported values.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state    <= IDLE;
            gate_cnt <= 32'd0;
            edge_cnt <= 32'd0;
            sat      <= 1'b0;
            freq     <= 32'd0;
            valid    <= 1'b0;
            overflow <= 1'b0;
`ifdef FREQ_METER_AVG_EN
            prev_result <= 32'd0;
            prev_sat    <= 1'b0;
            have_prev   <= 1'b0;
`endif
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state    <= MEASURE;
                        gate_cnt <= 32'd0;
                        edge_cnt <= 32'd0;
                        sat      <= 1'b0;
`ifdef FREQ_METER_AVG_EN
                        prev_result <= 32'd0;
                        prev_sat    <= 1'b0;
                        have_prev   <= 1'b0;
`endif
                    end
                end
                MEASURE: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (gate_cnt == LAST_GATE) begin
                        // Close the window and start the next one with no dead
                        // cycle. An edge on the following (wrap) cycle is
                        // counted in the new window.
                        gate_cnt <= 32'd0;
                        edge_cnt <= 32'd0;
                        sat      <= 1'b0;
                        valid    <= 1'b1;
`ifdef FREQ_METER_AVG_EN
                        if (have_prev) begin
                            freq     <= 32'((33'(result) + 33'(prev_result)) >> 1);
                            overflow <= result_sat | prev_sat;
                        end else begin
                            freq     <= result;
                            overflow <= result_sat;
                        end
                        prev_result <= result;
                        prev_sat    <= result_sat;
                        have_prev   <= 1'b1;
`else
                        freq     <= result;
                        overflow <= result_sat;
`endif
                    end else begin
                        gate_cnt <= gate_cnt + 32'd1;
                        if (edge_det) begin
                            if (cnt_full) begin
                                sat <= 1'b1;
                            end else begin
                                edge_cnt <= edge_cnt + 32'd1;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 100000000, the gate window length in CLOCK cycles; the default gives a 1 s window at 100 MHz.
REQ-002 SHALL have port CLOCK, input, 1 bit: the single system clock (100 MHz).
REQ-003 SHALL have port RESET, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port sig_in, input, 1 bit: signal to measure, asynchronous to CLOCK.
REQ-005 SHALL have port enable, input, 1 bit: measurement run/stop.
REQ-006 SHALL have port freq, output, 32 bits: rising edges counted in the last completed window (Hz at default GATE_CYCLES).
REQ-007 SHALL have port valid, output, 1 bit: one-cycle pulse when freq updates.
REQ-008 SHALL have port overflow, output, 1 bit: the edge count saturated in the window reported by freq.

Function
REQ-009 SHALL pass sig_in through a two-flop synchronizer plus one history flop, all running in every state.
REQ-010 SHALL detect a rising edge as sync2 high and history low; worst-case latency from sig_in to the counted edge is 3 cycles.
REQ-011 SHALL implement the states IDLE and MEASURE.
REQ-012 IDLE -> MEASURE on enable=1, clearing the gate counter and edge counter on that transition cycle.
REQ-013 MEASURE -> IDLE on enable=0 in any cycle, aborting the window: no valid pulse, and freq/overflow hold their last values.
REQ-014 In MEASURE, the gate counter SHALL increment every cycle from 0 to GATE_CYCLES-1.
REQ-015 In MEASURE, the edge counter SHALL add 1 per detected edge and saturate at 32'hFFFFFFFF, setting an internal sat flag.
REQ-016 On the cycle the gate counter equals GATE_CYCLES-1, the block SHALL compute the result as edge count plus the edge detected that cycle (saturating).
REQ-017 On the following cycle, freq SHALL take the result, overflow SHALL take sat, and valid SHALL be 1.
REQ-018 Windows SHALL run back-to-back with no dead cycle: the gate counter wraps to 0 and the edge counter restarts, so that an edge on the wrap cycle counts in the new window only.
REQ-019 An edge detected on the final cycle of a window SHALL be counted in the closing window, never twice.
REQ-020 Inputs toggling faster than CLOCK/2 alias; this is not detected or flagged.
REQ-021 enable rising on the cycle after a window abort SHALL start a fresh window.

Reset
REQ-022 RESET=1 SHALL force state IDLE and set freq=0, valid=0, overflow=0, all counters 0, and the synchronizer/history flops 0.
REQ-023 RESET SHALL take priority over enable and over window completion in the same cycle; a window completing on a reset cycle produces no valid pulse.

Configuration
REQ-024 With macro FREQ_METER_AVG_EN defined, freq SHALL be (current result + previous result) >> 1, computed with a 33-bit sum.
REQ-025 With FREQ_METER_AVG_EN defined, the first window after entering MEASURE SHALL report the current result only; overflow is the OR of sat for both windows; the previous-result register clears on reset and on entry to MEASURE.
REQ-026 Without FREQ_METER_AVG_EN, freq SHALL be the raw per-window result and no previous-result register exists.

Verification (GATE_CYCLES=1000)
REQ-027 Reset: assert RESET 5 cycles -> freq=0, valid=0, overflow=0, and the state is IDLE.
REQ-028 Steady input: sig_in period 10 cycles, enable=1 -> valid pulses every 1000 cycles with freq=100 each time.
REQ-029 Abort: enable falls at cycle 500 of the second window -> no valid pulse follows, and freq stays 100.
REQ-030 Fastest input and flat input: sig_in period 2 cycles -> freq=500; then sig_in held high -> next window freq=0.
REQ-031 Boundary edge: an edge timed to be detected exactly on cycle 999 -> counted once, in the closing window; the total over two windows equals the edges applied.
REQ-032 Averaging (FREQ_METER_AVG_EN): window 1 at period 10, window 2 at period 5 -> freq=100, then freq=150.
